// File: rtl/link_tx_sequencer.sv
// link_tx_sequencer
//   Feeds an 8b10b encoder with link bring-up commas, requester bytes and
//   periodic K28.5 alignment characters.
//
//   OFF   : idle commas, link down, nothing accepted.
//   ALIGN : ALIGN_COUNT commas, then RUN.
//   RUN   : requester bytes pass through with 1-cycle latency; idle commas
//           fill gaps, and one comma is forced every ALIGN_INTERVAL cycles.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   enable            : link enable; dropping it returns to OFF
//   s_data/s_k/s_valid: requester byte, control flag, offer
//   s_ready           : combinational accept for this cycle
//   enc_data/enc_k    : registered byte/flag to the encoder
//   enc_k_err         : invalid-K report from the encoder
//   link_up           : registered, high while in RUN
//   err_count         : saturating count of enc_k_err while not OFF
module link_tx_sequencer #(
    parameter int ALIGN_COUNT    = 16,
    parameter int ALIGN_INTERVAL = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] s_data,
    input  logic       s_k,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] enc_data,
    output logic       enc_k,
    input  logic       enc_k_err,
    output logic       link_up,
    output logic [7:0] err_count
);

    localparam logic [7:0]  K28_5         = 8'hBC;
    localparam logic [7:0]  ALIGN_LAST    = 8'(ALIGN_COUNT - 1);
    localparam logic [15:0] INTERVAL_LAST = 16'(ALIGN_INTERVAL - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_ALIGN,
        ST_RUN
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  align_cnt_q, align_cnt_d;
    logic [15:0] interval_cnt_q, interval_cnt_d;
    logic [7:0]  enc_data_q, enc_data_d;
    logic        enc_k_q, enc_k_d;
    logic        link_up_q, link_up_d;
    logic [7:0]  err_count_q, err_count_d;

    // The last slot of each interval is reserved for the inserted comma, so
    // a held request simply waits one cycle. Reset also masks acceptance.
    assign s_ready = ~rst & (state_q == ST_RUN) & enable
                     & (interval_cnt_q != INTERVAL_LAST);

    always_comb begin
        state_d        = state_q;
        align_cnt_d    = align_cnt_q;
        interval_cnt_d = interval_cnt_q;
        enc_data_d     = K28_5;
        enc_k_d        = 1'b1;
        link_up_d      = link_up_q;
        err_count_d    = err_count_q;

        if (enc_k_err && (state_q != ST_OFF) && (err_count_q != 8'hFF))
            err_count_d = err_count_q + 8'd1;

        case (state_q)
            ST_OFF: begin
                link_up_d = 1'b0;
                if (enable) begin
                    state_d     = ST_ALIGN;
                    align_cnt_d = 8'd0;
                end
            end
            ST_ALIGN: begin
                if (!enable) begin
                    state_d   = ST_OFF;
                    link_up_d = 1'b0;
                end else begin
                    align_cnt_d = align_cnt_q + 8'd1;
                    if (align_cnt_q == ALIGN_LAST) begin
                        state_d        = ST_RUN;
                        link_up_d      = 1'b1;
                        interval_cnt_d = 16'd0;
                    end
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d   = ST_OFF;
                    link_up_d = 1'b0;
                end else begin
                    interval_cnt_d = (interval_cnt_q == INTERVAL_LAST)
                                     ? 16'd0 : interval_cnt_q + 16'd1;
                    if (s_valid && s_ready) begin
                        enc_data_d = s_data;
                        enc_k_d    = s_k;
                    end
                end
            end
            default: begin
                state_d   = ST_OFF;
                link_up_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_OFF;
            align_cnt_q    <= 8'd0;
            interval_cnt_q <= 16'd0;
            enc_data_q     <= 8'h00;
            enc_k_q        <= 1'b0;
            link_up_q      <= 1'b0;
            err_count_q    <= 8'd0;
        end else begin
            state_q        <= state_d;
            align_cnt_q    <= align_cnt_d;
            interval_cnt_q <= interval_cnt_d;
            enc_data_q     <= enc_data_d;
            enc_k_q        <= enc_k_d;
            link_up_q      <= link_up_d;
            err_count_q    <= err_count_d;
        end
    end

    assign enc_data  = enc_data_q;
    assign enc_k     = enc_k_q;
    assign link_up   = link_up_q;
    assign err_count = err_count_q;

endmodule
